// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and parameter defaults.
package loader_pkg;

    localparam int ADDR_W_DEF   = 14;
    localparam int DATA_W_DEF   = 32;
    localparam int RST_HOLD_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/ld_counter.sv
// Loadable up-counter with a terminal-count flag (count equals tc_val_i).
module ld_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)         cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (en_i)   cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/prog_loader.sv
// Streams a program image into target memory, holds the core in reset for RST_HOLD
// cycles, then releases it; a start while running reloads the image.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RST_HOLD = RST_HOLD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_reset_x,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // RST_HOLD of 0 still spends one cycle in HOLD
    localparam int HOLD_LAST = (RST_HOLD > 0) ? RST_HOLD - 1 : 0;
    localparam int HW        = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;
    localparam logic [ADDR_W+1:0] MEM_WORDS = {2'b01, {ADDR_W{1'b0}}};

    ld_state_e         state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] last_q;
    logic              mem_we_q, done_q, err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [ADDR_W+1:0] end_addr;
    logic              ovf, can_start, go_load, go_hold0, bad_start;
    logic              accept, beat_last;
    logic [ADDR_W-1:0] beat_idx;
    logic              beat_tc, hold_tc;
    logic [HW-1:0]     hold_cnt_unused;

    assign end_addr  = {2'b00, base_addr} + {1'b0, length};
    assign ovf       = (end_addr > MEM_WORDS);
    assign can_start = start && (state_q == ST_IDLE || state_q == ST_RUN);
    assign go_load   = can_start && !ovf && (length != '0);
    assign go_hold0  = can_start && (length == '0);
    assign bad_start = can_start && ovf;
    assign accept    = s_valid && (state_q == ST_LOAD);
    assign beat_last = accept && beat_tc;

    ld_counter #(.W(ADDR_W)) u_beat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (go_load),
        .load_val_i ('0),
        .en_i       (accept),
        .tc_val_i   (last_q),
        .cnt_o      (beat_idx),
        .tc_o       (beat_tc)
    );

    ld_counter #(.W(HW)) u_hold_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (go_hold0 || beat_last),
        .load_val_i ('0),
        .en_i       (state_q == ST_HOLD),
        .tc_val_i   (HW'(HOLD_LAST)),
        .cnt_o      (hold_cnt_unused),
        .tc_o       (hold_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            last_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            mem_we_q <= accept;
            if (accept) begin
                mem_addr_q  <= base_q + beat_idx;
                mem_wdata_q <= s_data;
            end
            if (bad_start) err_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (go_load) begin
                        state_q <= ST_LOAD;
                        base_q  <= base_addr;
                        last_q  <= ADDR_W'(length - 1'b1);
                    end else if (go_hold0) begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_LOAD: if (beat_last) state_q <= ST_HOLD;
                ST_HOLD: begin
                    if (hold_tc) begin
                        state_q <= ST_RUN;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready      = (state_q == ST_LOAD);
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_HOLD);
    assign core_reset_x = (state_q == ST_RUN);
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at stimulus, matched on mem_we.
module tb_prog_loader;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int RH = 10;

    logic          clk = 1'b0;
    logic          rst, start, s_valid;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [DW-1:0] s_data;
    logic          s_ready, mem_we, core_reset_x, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t  sb_q[$];
    wr_t  exp_w;
    int   n_chk  = 0;
    int   n_err  = 0;
    int   n_done = 0;
    logic acc_prev = 1'b0;

    prog_loader #(.ADDR_W(AW), .DATA_W(DW), .RST_HOLD(RH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_reset_x (core_reset_x),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: latency-1 write after each accept, contents from the scoreboard
    always @(negedge clk) begin
        chk("we_latency", mem_we, acc_prev);
        if (mem_we) begin
            if (sb_q.size() == 0) chk("extra_write", 1, 0);
            else begin
                exp_w = sb_q.pop_front();
                chk("wr_addr", mem_addr, exp_w.a);
                chk("wr_data", mem_wdata, exp_w.d);
            end
        end
        if (done) n_done <= n_done + 1;
        acc_prev <= s_valid && s_ready && !rst;
    end

    task automatic push_exp(input logic [AW-1:0] b, input int n, input logic [DW-1:0] dbase);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.a = b + AW'(i);
            w.d = dbase + DW'(i);
            sb_q.push_back(w);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int len, input bit keep);
        start     = 1'b1;
        base_addr = b;
        length    = (AW+1)'(len);
        @(posedge clk); #1;
        if (!keep) start = 1'b0;
    endtask

    task automatic stream(input int n, input bit gaps, input logic [DW-1:0] dbase);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 200) begin
            s_valid = !(gaps && (cyc % 2 == 1));
            s_data  = dbase + DW'(i);
            @(negedge clk);
            if (s_valid && s_ready) i++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        if (i < n) chk("stream_timeout", i, n);
    endtask

    // Counts HOLD cycles until RUN, checks the single done pulse; drops start after drop_after cycles
    task automatic run_check(input string tag, input int drop_after);
        int hc = 0;
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (core_reset_x) seen = 1;
            else begin
                if (busy !== 1'b1) chk({tag, "_busy_hold"}, busy, 1);
                hc++;
                if (hc == drop_after) start = 1'b0;
                @(posedge clk); #1;
            end
        end
        chk({tag, "_run_seen"}, seen, 1);
        chk({tag, "_hold_cycles"}, hc, RH);
        chk({tag, "_done_first"}, done, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_done_once"}, done, 0);
        chk({tag, "_still_run"}, core_reset_x, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_ready"}, s_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_crx"}, core_reset_x, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired obs=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset("por");
        @(posedge clk); #1;

        // back-to-back load of four words
        push_exp(14'h10, 4, 32'hA0);
        do_start(14'h10, 4, 0);
        chk("t1_ready", s_ready, 1);
        chk("t1_busy", busy, 1);
        stream(4, 0, 32'hA0);
        run_check("t1", 0);
        chk("t1_sb_empty", sb_q.size(), 0);
        chk("t1_done_cnt", n_done, 1);

        // reload from RUN with s_valid gaps
        push_exp(14'h10, 4, 32'hB0);
        do_start(14'h10, 4, 0);
        chk("t2_crx_drop", core_reset_x, 0);
        stream(4, 1, 32'hB0);
        run_check("t2", 0);
        chk("t2_sb_empty", sb_q.size(), 0);

        // zero length, start kept high through part of HOLD (ignored)
        do_start(14'h55, 0, 1);
        chk("t3_ready", s_ready, 0);
        chk("t3_busy", busy, 1);
        run_check("t3", 5);
        chk("t3_done_cnt", n_done, 3);

        // single-word reload from RUN at address 0
        push_exp(14'h0, 1, 32'hC5);
        do_start(14'h0, 1, 0);
        chk("t5_crx_drop", core_reset_x, 0);
        chk("t5_ready", s_ready, 1);
        stream(1, 0, 32'hC5);
        run_check("t5", 0);
        chk("t5_done_cnt", n_done, 4);

        // overflow while running: err set, stays in RUN
        do_start(14'h3FFF, 2, 0);
        @(negedge clk);
        chk("ovr_run_err", err, 1);
        chk("ovr_run_crx", core_reset_x, 1);
        chk("ovr_run_busy", busy, 0);
        @(posedge clk); #1;

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst2");
        @(posedge clk); #1;

        // overflow from IDLE: err, no writes, stays IDLE
        do_start(14'h3FFE, 3, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t4_err", err, 1);
            chk("t4_busy", busy, 0);
            chk("t4_crx", core_reset_x, 0);
            chk("t4_ready", s_ready, 0);
            @(posedge clk); #1;
        end

        // load ending exactly at the top of memory is legal
        push_exp(14'h3FFC, 4, 32'hD0);
        do_start(14'h3FFC, 4, 0);
        chk("t4b_ready", s_ready, 1);
        chk("t4b_err_sticky", err, 1);
        stream(4, 0, 32'hD0);
        run_check("t4b", 0);
        chk("t4b_sb_empty", sb_q.size(), 0);

        // reset after two of four beats, with a third beat offered during reset
        push_exp(14'h20, 2, 32'hE0);
        do_start(14'h20, 4, 0);
        stream(2, 0, 32'hE0);
        rst = 1'b1; s_valid = 1'b1; s_data = 32'hEE;
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk_reset("t6");
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_idle_crx", core_reset_x, 0);
        chk("t6_idle_busy", busy, 0);
        chk("t6_sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
